// File: rtl/bus_cycle_master_if.sv
// Command and bus-pin bundle for bus_cycle_master.
// master modport: the bus initiator (accepts commands, drives the bus pins).
// slave modport : the requester/responder side (issues commands, drives READY).
// AD is bidirectional and is carried as a plain port on the master, not here.
interface bus_cycle_master_if;
  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 8;
  localparam int unsigned HAW = 12;
  localparam int unsigned WCW = 4;

  // requester side
  logic           req;
  logic           req_ready;
  logic           req_io;
  logic           req_wr;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic           done;
  logic           err;
  logic [DW-1:0]  rdata;
  logic [WCW-1:0] wait_cnt;

  // bus pins
  logic [HAW-1:0] A;
  logic           ALE;
  logic           RD;
  logic           WR;
  logic           IOM;
  logic           DTR;
  logic           DEN;
  logic           READY;

  modport master (
    input  req, req_io, req_wr, req_addr, req_wdata, READY,
    output req_ready, done, err, rdata, wait_cnt,
    output A, ALE, RD, WR, IOM, DTR, DEN
  );

  modport slave (
    output req, req_io, req_wr, req_addr, req_wdata, READY,
    input  req_ready, done, err, rdata, wait_cnt,
    input  A, ALE, RD, WR, IOM, DTR, DEN
  );
endinterface

// File: rtl/bus_cycle_master.sv
// 8088-style minimum-mode bus initiator: turns single-byte read/write
// commands into multiplexed T1-T4 bus cycles with READY-driven wait states
// and an optional wait-state timeout.
// Ports:
//   CLK    - clock, all state changes on posedge
//   RESET  - synchronous active-high reset
//   bus    - command handshake, status and bus pins (master modport)
//   AD     - multiplexed address/data, high-Z when not driven
module bus_cycle_master #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bus_cycle_master_if.master   bus,
  inout  wire  [7:0]           AD
);
  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 8;
  localparam int unsigned HAW = 12;
  localparam int unsigned WCW = 4;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

  typedef struct packed {
    logic          io;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  // Registered pin image; rdy doubles as req_ready.
  typedef struct packed {
    logic           ale;
    logic           rd;
    logic           wr;
    logic           den;
    logic           dtr;
    logic           iom;
    logic [HAW-1:0] a;
    logic           oe;
    logic [DW-1:0]  ad;
    logic           rdy;
  } pins_t;

  state_t         state;
  cmd_t           cmd_q;
  pins_t          pins_q;
  logic           done_q;
  logic           err_q;
  logic [DW-1:0]  rdata_q;
  logic [WCW-1:0] wait_cnt_q;

  cmd_t           new_cmd_c;
  logic           accept_c;
  logic           timeout_c;

  // Pin values for a given bus state and latched command.
  function automatic pins_t decode(input state_t s, input cmd_t c);
    pins_t p;
    p     = '0;
    p.rd  = 1'b1;
    p.wr  = 1'b1;
    p.den = 1'b1;
    p.dtr = 1'b1;
    case (s)
      IDLE: p.rdy = 1'b1;
      T1: begin
        p.ale = 1'b1;
        p.a   = c.addr[AW-1:DW];
        p.iom = c.io;
        p.dtr = c.wr;
        p.oe  = 1'b1;
        p.ad  = c.addr[DW-1:0];
      end
      T2, T3, TW: begin
        p.a   = c.addr[AW-1:DW];
        p.iom = c.io;
        p.dtr = c.wr;
        p.den = 1'b0;
        if (c.wr) begin
          p.wr = 1'b0;
          p.oe = 1'b1;
          p.ad = c.wdata;
        end else begin
          p.rd = 1'b0;
        end
      end
      T4: begin
        p.a   = c.addr[AW-1:DW];
        p.iom = c.io;
        p.dtr = c.wr;
        p.rdy = 1'b1;
      end
      default: p.rdy = 1'b1;
    endcase
    return p;
  endfunction

  // I/O cycles only carry a 16-bit port address.
  assign new_cmd_c = {bus.req_io, bus.req_wr,
                      bus.req_io ? {4'h0, bus.req_addr[15:0]} : bus.req_addr,
                      bus.req_wdata};
  assign accept_c  = bus.req && pins_q.rdy;
  assign timeout_c = (MAX_WAIT != 0) && (32'(wait_cnt_q) >= MAX_WAIT);

  // Bus state machine with registered pins and status.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cmd_q      <= '0;
      pins_q     <= decode(IDLE, cmd_t'('0));
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, T4: begin
          if (accept_c) begin
            state      <= T1;
            cmd_q      <= new_cmd_c;
            pins_q     <= decode(T1, new_cmd_c);
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
          end else begin
            state  <= IDLE;
            pins_q <= decode(IDLE, cmd_q);
          end
        end
        T1: begin
          state  <= T2;
          pins_q <= decode(T2, cmd_q);
        end
        T2: begin
          state  <= T3;
          pins_q <= decode(T3, cmd_q);
        end
        T3, TW: begin
          if (bus.READY) begin
            state  <= T4;
            pins_q <= decode(T4, cmd_q);
            done_q <= 1'b1;
            err_q  <= 1'b0;
            if (!cmd_q.wr) rdata_q <= AD;
          end else if ((state == TW) && timeout_c) begin
            // Abandon the cycle; reads return all-ones.
            state  <= T4;
            pins_q <= decode(T4, cmd_q);
            done_q <= 1'b1;
            err_q  <= 1'b1;
            if (!cmd_q.wr) rdata_q <= 8'hFF;
          end else begin
            state  <= TW;
            pins_q <= decode(TW, cmd_q);
            if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          pins_q <= decode(IDLE, cmd_q);
        end
      endcase
    end
  end

  assign AD = pins_q.oe ? pins_q.ad : {DW{1'bz}};

  assign bus.req_ready = pins_q.rdy;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.wait_cnt  = wait_cnt_q;
  assign bus.A         = pins_q.a;
  assign bus.ALE       = pins_q.ale;
  assign bus.RD        = pins_q.rd;
  assign bus.WR        = pins_q.wr;
  assign bus.IOM       = pins_q.iom;
  assign bus.DTR       = pins_q.dtr;
  assign bus.DEN       = pins_q.den;
endmodule

// File: tb/tb_bus_cycle_master.sv
// Bench for bus_cycle_master: directed commands, a phase-table model of the
// expected pin/status values per cycle, a small byte-wide responder memory,
// and a negedge compare process.
module tb_bus_cycle_master;
  localparam int unsigned MAXW = 3;
  localparam logic [7:0]  MARK = 8'hE7;   // value the bench parks on AD when the master must float it

  typedef enum {P_IDLE, P_T1, P_T2, P_T3, P_TW, P_T4} ph_t;

  typedef struct {
    logic io;
    logic wr;
    logic [19:0] ea;
    logic [7:0] wd;
  } tcmd_t;

  typedef struct {
    logic ale, rd, wr, den, dtr, iom;
    logic [11:0] a;
    logic [7:0] ad;
    logic done, err;
    logic [7:0] rdata;
    logic [3:0] wcnt;
    logic rdy;
  } exp_t;

  logic CLK;
  logic RESET;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  bus_cycle_master_if bif();
  wire  [7:0] AD;
  logic       tb_oe;
  logic [7:0] tb_val;
  assign AD = tb_oe ? tb_val : 8'hzz;

  bus_cycle_master #(.MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bif.master), .AD(AD)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic chk_en;
  exp_t e;
  logic [7:0] m_rdata;
  logic [3:0] m_wcnt;
  logic [7:0] mem [logic [20:0]];
  logic [20:0] lat_key;
  int acc_cyc, d_cyc;
  logic [7:0] d_rdata, t1_ad;
  logic [3:0] d_wcnt;
  logic d_err, t1_iom;
  logic [11:0] t1_a;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [7:0] mem_get(input logic [20:0] k);
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  // Expected pins for one bus phase of a command.
  function automatic exp_t pexp(input ph_t ph, input tcmd_t c, input logic [7:0] rsp);
    exp_t x;
    x.ale = 0; x.rd = 1; x.wr = 1; x.den = 1; x.dtr = 1; x.iom = 0; x.a = '0;
    x.ad = MARK; x.done = 0; x.err = 0; x.rdata = '0; x.wcnt = '0; x.rdy = 0;
    if (ph != P_IDLE) begin
      x.iom = c.io; x.dtr = c.wr; x.a = c.ea[19:8];
    end
    case (ph)
      P_IDLE: x.rdy = 1;
      P_T1:   begin x.ale = 1; x.ad = c.ea[7:0]; end
      P_T4:   begin x.done = 1; x.rdy = 1; end
      default: begin
        x.den = 0;
        if (c.wr) begin x.wr = 0; x.ad = c.wd; end
        else begin x.rd = 0; x.ad = rsp; end
      end
    endcase
    return x;
  endfunction

  task automatic stage(input ph_t ph, input tcmd_t c, input logic [7:0] rsp,
                       input int wc, input logic rdy);
    e = pexp(ph, c, rsp);
    e.rdata = m_rdata;
    e.wcnt  = 4'(wc);
    bif.READY = rdy;
    tb_oe  = (ph == P_T4) || (!c.wr && (ph == P_T2 || ph == P_T3 || ph == P_TW));
    tb_val = (ph == P_T4) ? MARK : rsp;
  endtask

  task automatic set_idle();
    tcmd_t c0;
    c0.io = 0; c0.wr = 0; c0.ea = '0; c0.wd = '0;
    stage(P_IDLE, c0, 8'h00, 0, 1'b0);
    e.wcnt = m_wcnt;
    tb_oe  = 1'b1;
    tb_val = MARK;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      set_idle();
    end
  endtask

  // Issue a command and follow it to its T4 cycle (returns inside T4).
  task automatic xfer(input logic io, input logic wr, input logic [19:0] addr,
                      input logic [7:0] wd, input int nw, input logic tmo);
    tcmd_t c;
    logic [7:0] rsp;
    c.io = io; c.wr = wr; c.wd = wd;
    c.ea = io ? {4'h0, addr[15:0]} : addr;
    bif.req = 1; bif.req_io = io; bif.req_wr = wr;
    bif.req_addr = addr; bif.req_wdata = wd;
    acc_cyc = cyc;
    @(posedge CLK); #1;
    bif.req = 0;
    rsp = mem_get({io, c.ea});
    stage(P_T1, c, rsp, 0, 1'b1);
    @(posedge CLK); #1;
    stage(P_T2, c, rsp, 0, 1'b0);
    @(posedge CLK); #1;
    for (int i = 0; i <= nw; i++) begin
      if (i == 0) stage(P_T3, c, rsp, 0, !tmo && (i >= nw));
      else        stage(P_TW, c, rsp, i, !tmo && (i >= nw));
      @(posedge CLK); #1;
    end
    if (!wr) m_rdata = tmo ? 8'hFF : rsp;
    m_wcnt = 4'(nw);
    stage(P_T4, c, rsp, nw, 1'b0);
    e.err = tmo;
  endtask

  // Per-cycle compare plus the responder (address latch and write strobe).
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ALE", 32'(bif.ALE), 32'(e.ale));
      chk("RD", 32'(bif.RD), 32'(e.rd));
      chk("WR", 32'(bif.WR), 32'(e.wr));
      chk("DEN", 32'(bif.DEN), 32'(e.den));
      chk("DTR", 32'(bif.DTR), 32'(e.dtr));
      chk("IOM", 32'(bif.IOM), 32'(e.iom));
      chk("A", 32'(bif.A), 32'(e.a));
      chk("AD", 32'(AD), 32'(e.ad));
      chk("done", 32'(bif.done), 32'(e.done));
      if (e.done) chk("err", 32'(bif.err), 32'(e.err));
      chk("rdata", 32'(bif.rdata), 32'(e.rdata));
      chk("wait_cnt", 32'(bif.wait_cnt), 32'(e.wcnt));
      chk("req_ready", 32'(bif.req_ready), 32'(e.rdy));
    end
    if (bif.done) begin
      d_cyc = cyc; d_rdata = bif.rdata; d_err = bif.err; d_wcnt = bif.wait_cnt;
    end
    if (bif.ALE) begin
      lat_key = {bif.IOM, bif.A, AD};
      t1_ad = AD; t1_a = bif.A; t1_iom = bif.IOM;
    end
    if (!bif.WR && bif.READY) mem[lat_key] = AD;
  end

  initial begin
    int a1;
    tcmd_t c;
    chk_en = 0;
    lat_key = '0;
    mem[{1'b0, 20'h00123}] = 8'h3C;
    mem[{1'b1, 20'h0FF04}] = 8'h5E;
    mem[{1'b0, 20'h00200}] = 8'h77;
    m_rdata = '0; m_wcnt = '0;

    // Reset with a pending command: reset must win over acceptance.
    RESET = 1; bif.req = 1; bif.req_io = 0; bif.req_wr = 1;
    bif.req_addr = 20'h12345; bif.req_wdata = 8'h5A; bif.READY = 1;
    set_idle();
    @(posedge CLK); #1;
    set_idle();
    chk_en = 1;
    @(posedge CLK); #1;
    RESET = 0; bif.req = 0;
    set_idle();
    chk("rst_rdata", 32'(bif.rdata), 32'h0);
    chk("rst_err", 32'(bif.err), 32'h0);
    chk("rst_req_ready", 32'(bif.req_ready), 32'h1);
    idle(1);

    // Memory write, zero waits.
    xfer(1'b0, 1'b1, 20'h80010, 8'hA5, 0, 1'b0);
    idle(1);
    chk("wr_t1_ad", 32'(t1_ad), 32'h10);
    chk("wr_t1_a", 32'(t1_a), 32'h800);
    chk("wr_latency", 32'(d_cyc - acc_cyc), 32'd4);
    chk("wr_mem", 32'(mem_get({1'b0, 20'h80010})), 32'hA5);

    // Memory read, zero waits.
    xfer(1'b0, 1'b0, 20'h00123, 8'h00, 0, 1'b0);
    idle(1);
    chk("rd_rdata", 32'(d_rdata), 32'h3C);
    chk("rd_err", 32'(d_err), 32'h0);
    chk("rd_wcnt", 32'(d_wcnt), 32'h0);

    // I/O read, two waits; upper request address bits must be dropped.
    xfer(1'b1, 1'b0, 20'hAFF04, 8'h00, 2, 1'b0);
    idle(1);
    chk("io_wcnt", 32'(d_wcnt), 32'd2);
    chk("io_latency", 32'(d_cyc - acc_cyc), 32'd6);
    chk("io_t1_a", 32'(t1_a), 32'h0FF);
    chk("io_t1_iom", 32'(t1_iom), 32'h1);
    chk("io_rdata", 32'(d_rdata), 32'h5E);

    // READY stuck low: timeout after MAXW wait states.
    xfer(1'b0, 1'b0, 20'h00200, 8'h00, 3, 1'b1);
    idle(1);
    chk("to_rdata", 32'(d_rdata), 32'hFF);
    chk("to_err", 32'(d_err), 32'h1);
    chk("to_wcnt", 32'(d_wcnt), 32'd3);
    chk("to_latency", 32'(d_cyc - acc_cyc), 32'd7);

    // READY arrives on the edge the timeout would fire: normal completion.
    xfer(1'b0, 1'b0, 20'h00200, 8'h00, 3, 1'b0);
    idle(1);
    chk("edge_rdata", 32'(d_rdata), 32'h77);
    chk("edge_err", 32'(d_err), 32'h0);

    // Back-to-back write then read of the same byte.
    xfer(1'b0, 1'b1, 20'h00010, 8'h11, 0, 1'b0);
    a1 = acc_cyc;
    xfer(1'b0, 1'b0, 20'h00010, 8'h00, 0, 1'b0);
    idle(1);
    chk("b2b_done_cyc", 32'(d_cyc - a1), 32'd8);
    chk("b2b_rdata", 32'(d_rdata), 32'h11);

    // Reset during T2 of a write: command dropped, rdata cleared.
    c.io = 0; c.wr = 1; c.ea = 20'h00040; c.wd = 8'h99;
    bif.req = 1; bif.req_io = 0; bif.req_wr = 1;
    bif.req_addr = 20'h00040; bif.req_wdata = 8'h99;
    @(posedge CLK); #1;
    bif.req = 0;
    stage(P_T1, c, 8'h00, 0, 1'b1);
    @(posedge CLK); #1;
    stage(P_T2, c, 8'h00, 0, 1'b0);
    RESET = 1;
    @(posedge CLK); #1;
    RESET = 0;
    m_rdata = '0; m_wcnt = '0;
    set_idle();
    idle(1);
    chk("rst_drop", 32'(mem.exists({1'b0, 20'h00040})), 32'h0);

    // Normal command after the mid-cycle reset.
    xfer(1'b0, 1'b0, 20'h80010, 8'h00, 1, 1'b0);
    idle(2);
    chk("post_rst_rdata", 32'(d_rdata), 32'hA5);
    chk("post_rst_wcnt", 32'(d_wcnt), 32'd1);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
